// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the four-digit BCD stopwatch.
// FSM encoding, BCD widths and the digit increment helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } sw_state_t;

    localparam int         BCD_DIGITS = 4;
    localparam int         BCD_W      = 16;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    // Wraps anything at or above 9 back to 0, so a digit can never go non-BCD.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter
// and a one-cycle pulse on an accepted press (1->0).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after an unbroken run of mismatching cycles.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        press_d = level_prev_q & ~level_q;
    end

    // Accepted level, its delayed copy and the press pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            press_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Four-digit BCD stopwatch: button conditioning, start/pause/lap/clear
// FSM, count prescaler and the cascaded decade counter chain.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = 5_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_ss_n,
    input  logic             btn_lc_n,
    output logic [BCD_W-1:0] disp_bcd,
    output logic             run,
    output logic             lap_active,
    output logic             overflow,
    output logic             tick,
    output logic [1:0]       state
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    sw_state_t        state_q;
    sw_state_t        state_d;
    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic [BCD_W-1:0] cnt_q;
    logic [BCD_W-1:0] cnt_d;
    logic [BCD_W-1:0] lap_q;
    logic [BCD_W-1:0] lap_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             tick_q;
    logic             ss_ev;
    logic             lc_raw;
    logic             lc_ev;
    logic             counting;
    logic             clear;
    logic             lap_take;
    logic             cnt_en;
    logic             wrap;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_ss (
        .clk  (clk),
        .reset(reset),
        .btn_n(btn_ss_n),
        .press(ss_ev)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_lc (
        .clk  (clk),
        .reset(reset),
        .btn_n(btn_lc_n),
        .press(lc_raw)
    );

    // Start/stop has priority; a coincident lap/clear press is dropped.
    assign lc_ev = lc_raw & ~ss_ev;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (ss_ev) state_d = S_RUN;
            end
            S_RUN: begin
                if (ss_ev)      state_d = S_PAUSE;
                else if (lc_ev) state_d = S_LAP;
            end
            S_LAP: begin
                if (ss_ev)      state_d = S_PAUSE;
                else if (lc_ev) state_d = S_RUN;
            end
            S_PAUSE: begin
                if (ss_ev)      state_d = S_RUN;
                else if (lc_ev) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and datapath controls.
    always_comb begin
        counting   = (state_q == S_RUN) || (state_q == S_LAP);
        lap_active = (state_q == S_LAP);
        clear      = (state_q == S_PAUSE) && lc_ev;
        lap_take   = (state_q == S_RUN) && lc_ev;
    end

    assign cnt_en = counting && (presc_q == PRESC_LAST);

    // Prescaler: runs while counting, holds in PAUSE, zero in IDLE.
    always_comb begin
        presc_d = presc_q;
        if (clear || (state_q == S_IDLE)) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = cnt_en ? '0 : presc_q + PW'(1);
        end
    end

    // Decade chain: each digit steps when every lower digit is at 9.
    always_comb begin
        logic       carry;
        logic [3:0] dig;
        carry = cnt_en;
        cnt_d = cnt_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            dig = cnt_q[4*i +: 4];
            if (carry) cnt_d[4*i +: 4] = bcd_inc(dig);
            carry = carry && (dig >= BCD_MAX);
        end
        wrap  = carry;
        ovf_d = ovf_q | wrap;
        lap_d = lap_take ? cnt_q : lap_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
            lap_q   <= '0;
            ovf_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            lap_q   <= lap_d;
            ovf_q   <= ovf_d;
            tick_q  <= cnt_en;
        end
    end

    assign run      = counting;
    assign overflow = ovf_q;
    assign tick     = tick_q;
    assign state    = state_q;
    assign disp_bcd = lap_active ? lap_q : cnt_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Expectations are queued with their due cycle and compared at negedge.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int F_STATE = 0;
    localparam int F_DISP  = 1;
    localparam int F_RUN   = 2;
    localparam int F_LAP   = 3;
    localparam int F_OVF   = 4;
    localparam int F_TICK  = 5;

    typedef struct {
        int          at;
        int          fld;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_ss_n;
    logic        btn_lc_n;
    logic [15:0] disp_bcd;
    logic        run;
    logic        lap_active;
    logic        overflow;
    logic        tick;
    logic [1:0]  state;

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    stopwatch_ctrl #(
        .TICK_DIV(4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_ss_n  (btn_ss_n),
        .btn_lc_n  (btn_lc_n),
        .disp_bcd  (disp_bcd),
        .run       (run),
        .lap_active(lap_active),
        .overflow  (overflow),
        .tick      (tick),
        .state     (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] probe(int f);
        case (f)
            F_STATE: return {30'd0, state};
            F_DISP:  return {16'd0, disp_bcd};
            F_RUN:   return {31'd0, run};
            F_LAP:   return {31'd0, lap_active};
            F_OVF:   return {31'd0, overflow};
            default: return {31'd0, tick};
        endcase
    endfunction

    function automatic string fname(int f);
        case (f)
            F_STATE: return "state";
            F_DISP:  return "disp";
            F_RUN:   return "run";
            F_LAP:   return "lap";
            F_OVF:   return "ovf";
            default: return "tick";
        endcase
    endfunction

    task automatic push(int at, int f, logic [15:0] v);
        exp_t e;
        e.at  = at;
        e.fld = f;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic goto(int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
        check("sched", cyc, t);
    endtask

    task automatic chk_zero(string tag);
        check({tag, "_state"}, {30'd0, state}, 0);
        check({tag, "_disp"}, {16'd0, disp_bcd}, 0);
        check({tag, "_run"}, {31'd0, run}, 0);
        check({tag, "_lap"}, {31'd0, lap_active}, 0);
        check({tag, "_ovf"}, {31'd0, overflow}, 0);
        check({tag, "_tick"}, {31'd0, tick}, 0);
    endtask

    // Compare every queued expectation that has fallen due.
    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].at <= cyc) begin
                check($sformatf("%s@%0d", fname(sbq[i].fld), sbq[i].at),
                      probe(sbq[i].fld), {16'd0, sbq[i].val});
                sbq.delete(i);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int r;
        int r2;
        int r3;
        int w;

        reset    = 1'b0;
        btn_ss_n = 1'b1;
        btn_lc_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        reset = 1'b1;

        // Bounce: two short lows never reach the debounce threshold.
        c = cyc + 2;
        for (int k = 0; k <= 15; k++) push(c + k, F_STATE, 0);
        push(c + 15, F_DISP, 16'h0000);
        goto(c);
        btn_ss_n = 1'b0;
        goto(c + 2);
        btn_ss_n = 1'b1;
        goto(c + 3);
        btn_ss_n = 1'b0;
        goto(c + 5);
        btn_ss_n = 1'b1;
        goto(c + 20);

        // Start from IDLE, first ticks, count to 10.
        c = cyc + 1;
        r = c + 7;
        push(c + 6, F_STATE, 0);
        push(c + 6, F_RUN, 0);
        push(r, F_STATE, 1);
        push(r, F_RUN, 1);
        push(r + 3, F_DISP, 16'h0000);
        push(r + 4, F_DISP, 16'h0001);
        push(r + 4, F_TICK, 1);
        push(r + 5, F_TICK, 0);
        push(r + 7, F_TICK, 0);
        push(r + 8, F_TICK, 1);
        push(r + 40, F_DISP, 16'h0010);
        push(r + 43, F_DISP, 16'h0010);
        push(r + 44, F_DISP, 16'h0011);
        push(r + 148, F_DISP, 16'h0037);
        goto(c);
        btn_ss_n = 1'b0;
        goto(c + 10);
        btn_ss_n = 1'b1;

        // Reset mid-run at 0037 with start/stop held through it.
        goto(r + 149);
        btn_ss_n = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_zero("midrst");
        goto(r + 152);
        reset = 1'b1;
        c  = cyc;
        r2 = c + 7;
        push(c + 3, F_DISP, 16'h0000);
        push(c + 6, F_STATE, 0);
        push(c + 6, F_DISP, 16'h0000);
        push(r2, F_STATE, 1);
        push(r2 + 3, F_DISP, 16'h0000);
        push(r2 + 4, F_DISP, 16'h0001);

        // Lap entered on the edge a tick lands: 0005 latched, 0006 counted.
        push(r2 + 23, F_STATE, 1);
        push(r2 + 24, F_STATE, 3);
        push(r2 + 24, F_LAP, 1);
        push(r2 + 24, F_RUN, 1);
        push(r2 + 24, F_DISP, 16'h0005);
        push(r2 + 24, F_TICK, 1);
        push(r2 + 28, F_DISP, 16'h0005);
        push(r2 + 28, F_TICK, 1);
        push(r2 + 47, F_DISP, 16'h0005);
        push(r2 + 49, F_STATE, 3);
        push(r2 + 50, F_STATE, 1);
        push(r2 + 50, F_LAP, 0);
        push(r2 + 50, F_DISP, 16'h0012);
        push(r2 + 52, F_DISP, 16'h0013);

        // Both buttons at once: pause wins, count held at 0015.
        push(r2 + 62, F_STATE, 1);
        push(r2 + 62, F_DISP, 16'h0015);
        push(r2 + 63, F_STATE, 2);
        push(r2 + 63, F_LAP, 0);
        push(r2 + 63, F_RUN, 0);
        push(r2 + 63, F_DISP, 16'h0015);
        push(r2 + 64, F_TICK, 0);
        push(r2 + 75, F_DISP, 16'h0015);

        // Resume: prescaler was held at its last value, tick is immediate.
        r3 = r2 + 87;
        push(r3, F_STATE, 1);
        push(r3, F_DISP, 16'h0015);
        push(r3, F_TICK, 0);
        push(r3 + 1, F_DISP, 16'h0016);
        push(r3 + 1, F_TICK, 1);
        push(r3 + 5, F_DISP, 16'h0017);

        goto(c + 10);
        btn_ss_n = 1'b1;
        goto(r2 + 17);
        btn_lc_n = 1'b0;
        goto(r2 + 22);
        btn_lc_n = 1'b1;
        goto(r2 + 43);
        btn_lc_n = 1'b0;
        goto(r2 + 48);
        btn_lc_n = 1'b1;
        goto(r2 + 56);
        btn_ss_n = 1'b0;
        btn_lc_n = 1'b0;
        goto(r2 + 61);
        btn_ss_n = 1'b1;
        btn_lc_n = 1'b1;
        goto(r2 + 80);
        btn_ss_n = 1'b0;
        goto(r2 + 85);
        btn_ss_n = 1'b1;

        // Wrap 9999 -> 0000, sticky overflow, then pause and clear.
        w = r3 + 1 + 4 * 9984;
        push(w - 4, F_DISP, 16'h9999);
        push(w - 1, F_OVF, 0);
        push(w, F_DISP, 16'h0000);
        push(w, F_OVF, 1);
        push(w, F_TICK, 1);
        push(w + 10, F_OVF, 1);
        push(w + 21, F_STATE, 2);
        push(w + 21, F_OVF, 1);
        push(w + 21, F_DISP, 16'h0005);
        push(w + 25, F_DISP, 16'h0005);
        push(w + 36, F_STATE, 2);
        push(w + 36, F_OVF, 1);
        push(w + 37, F_STATE, 0);
        push(w + 37, F_DISP, 16'h0000);
        push(w + 37, F_OVF, 0);
        push(w + 57, F_STATE, 0);
        push(w + 60, F_STATE, 0);
        push(w + 60, F_DISP, 16'h0000);
        push(w + 77, F_STATE, 1);
        push(w + 80, F_DISP, 16'h0000);
        push(w + 81, F_DISP, 16'h0001);
        push(w + 81, F_TICK, 1);
        goto(w + 14);
        btn_ss_n = 1'b0;
        goto(w + 19);
        btn_ss_n = 1'b1;
        goto(w + 30);
        btn_lc_n = 1'b0;
        goto(w + 35);
        btn_lc_n = 1'b1;

        // Lap/clear is ignored in IDLE; then restart from a cleared prescaler.
        goto(w + 50);
        btn_lc_n = 1'b0;
        goto(w + 55);
        btn_lc_n = 1'b1;
        goto(w + 70);
        btn_ss_n = 1'b0;
        goto(w + 75);
        btn_ss_n = 1'b1;
        goto(w + 90);

        check("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Four-digit BCD stopwatch controller for the lab board: debounces the start/stop and lap/clear push buttons, runs a start/pause/lap/clear state machine, generates the count tick, and sequences a cascaded 0000–9999 decade counter chain. It sits between the raw board buttons and the seven-segment display driver, which consumes `disp_bcd`. The design is single clock domain. There are no derived clocks; all timing uses clock enables on `clk`.

## Interface
- `TICK_DIV`, default 5_000_000: clk cycles per count tick (10 Hz at 50 MHz); must be ≥2.
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable cycles before a button level is accepted; must be ≥1.
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `btn_ss_n`, input, 1: raw start/stop button, active-low, asynchronous to `clk`.
- `btn_lc_n`, input, 1: raw lap/clear button, active-low, asynchronous to `clk`.
- `disp_bcd`, output, 16: displayed value, 4 BCD digits, [15:12] most significant.
- `run`, output, 1: high in RUN or LAP.
- `lap_active`, output, 1: high in LAP.
- `overflow`, output, 1: sticky; set on 9999→0000 wrap.
- `tick`, output, 1: one-cycle pulse, high in the cycle a new count value first appears.
- `state`, output, 2: current FSM state.

## Operation
- Button path, per button: 2-FF synchronizer, then stability counter. The accepted level changes only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any mismatch gap restarts the counter.
- Press event: a one-cycle pulse on an accepted 1→0 transition. Release generates no event.
- FSM states, encoded: IDLE=0, RUN=1, PAUSE=2, LAP=3.
  - IDLE: ss → RUN. lc is ignored.
  - RUN: ss → PAUSE. lc → LAP, latching the current count into the lap register.
  - LAP: lc → RUN (display goes live). ss → PAUSE (display goes live).
  - PAUSE: ss → RUN. lc → IDLE, clearing the count, prescaler and `overflow`.
- Simultaneous ss and lc events in the same cycle: ss wins and the lc event is dropped.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 only in RUN and LAP.
  - Holds its value in PAUSE.
  - Is zero in IDLE.
- Internal tick enable is asserted when prescaler = `TICK_DIV`-1 and state is RUN or LAP.
- Count: four cascaded decade digits, each 0–9. A digit increments when all lower digits are 9 on a tick. 9999 + tick → 0000 and sets `overflow`.
- The count never holds non-BCD values.
- `disp_bcd` shows the lap register in LAP and the live count otherwise.

## Timing
- Reset (asynchronous, immediate) sets all outputs to 0, state to IDLE, accepted button levels to 1 (released), and clears all counters.
  - Reset mid-operation discards any in-flight debounce count.
  - After release, the first press needs the full debounce.
- Button latency: with a raw button held low from cycle 0, the press event is high in cycle `DEBOUNCE_CYCLES`+3, and `state`/`run` change on the following edge.
- Tick latency:
  - The count updates on the edge where the internal enable is high.
  - `tick` and the new `disp_bcd` (when not in LAP) are visible together in the next cycle.
- First tick after IDLE→RUN: the count reads 0001 exactly `TICK_DIV` cycles after `run` rises.
- Entering LAP: the lap register captures the count as it stands on that edge. A tick coinciding with the lc event is counted but not latched.
- PAUSE→RUN resumes the prescaler from its held value, so no partial tick is lost.
- `overflow` stays set until PAUSE+lc or reset.

## Structure
- Shared package `stopwatch_pkg` holds:
  - The state enum (IDLE/RUN/PAUSE/LAP, 2-bit).
  - `BCD_DIGITS` = 4.
  - `BCD_W` = 16.
  - The BCD max digit constant 9.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `btn_n`, `press`) contains the synchronizer, the stability counter and the edge pulse. It is instantiated twice.
- Decade chain, prescaler and FSM live in `stopwatch_ctrl`.

## Test plan
Use `TICK_DIV`=4 and `DEBOUNCE_CYCLES`=3.
- Reset, hold `btn_ss_n` low 10 cycles → `state`=RUN in cycle 7. `disp_bcd`=0x0010 after 40 further cycles. `tick` pulses every 4 cycles.
- Bounce: in IDLE, drive `btn_ss_n` low 2 cycles, high 1, low 2, high → no press event; `state` stays IDLE and `disp_bcd`=0x0000.
- Lap:
  - In RUN at count 0005, press lc → LAP, `disp_bcd` frozen at 0x0005 while `tick` continues.
  - Press lc at internal count 0012 → RUN, `disp_bcd`=0x0012.
- Wrap: run 10000 ticks → `disp_bcd`=0x0000 and `overflow`=1. Press ss, then lc → IDLE and `overflow`=0.
- Simultaneous: in RUN, press both buttons so their events land in the same cycle → PAUSE, `lap_active`=0, count held.
- Reset mid-run: at count 0037 assert `reset` → all outputs 0 and `state`=IDLE in the same cycle. After release, the count stays 0x0000 until a full debounced ss press.
